// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-based transmit link.
package credit_pkg;

   localparam int STATS_W   = 32;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

   // Credit count at the default remote fifo depth.
   typedef logic [DEF_CNT_W-1:0] credit_t;

   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/handshake_if.sv
// Generic valid/ready/data handshake bundle.
interface handshake_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport sender   (output valid, output data, input ready);
   modport receiver (input valid, input data, output ready);
endinterface

// File: rtl/credit_counter.sv
// Saturating up/down credit counter, initialised full, with a sticky overflow flag.
module credit_counter
   import credit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = credit_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      // inc and dec together cancel, so the only edges to guard are full+inc and empty+dec.
      if (inc && !dec) begin
         if (count_q == FULL) ovf_d   = 1'b1;
         else                 count_d = count_q + 1'b1;
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= FULL;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/credit_tx.sv
// Transmit end of a credit-based link into a remote fifo of DEPTH entries.
// Optional beat/stall statistics are built when CREDIT_TX_STATS_EN is defined.
module credit_tx
   import credit_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 4,
   localparam int CNT_W      = credit_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   handshake_if.receiver         receiver,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  credit_return,
   output logic [CNT_W-1:0]      credits,
   output logic                  idle,
   output logic                  credit_err
`ifdef CREDIT_TX_STATS_EN
  ,output logic [STATS_W-1:0]    beats_sent,
   output logic [STATS_W-1:0]    stall_cycles
`endif
);

   logic                  fire;
   logic                  ready;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

   credit_counter #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_credit_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (credit_return),
      .dec      (fire),
      .count    (credits),
      .overflow (credit_err)
   );

   // Ready comes only from the registered count so no combinational path crosses the link.
   assign ready          = (credits != '0);
   assign receiver.ready = ready;
   assign fire           = receiver.valid & ready;

   always_comb begin
      tx_valid_d = fire;
      tx_data_d  = tx_data_q;
      if (fire) tx_data_d = receiver.data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign idle     = (credits == CNT_W'(DEPTH)) && !tx_valid_q;

`ifdef CREDIT_TX_STATS_EN
   logic [STATS_W-1:0] beats_q, beats_d;
   logic [STATS_W-1:0] stall_q, stall_d;

   always_comb begin
      beats_d = beats_q;
      stall_d = stall_q;
      if (fire)                    beats_d = beats_q + 1'b1;
      if (receiver.valid && !ready) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         beats_q <= beats_d;
         stall_q <= stall_d;
      end
   end

   assign beats_sent   = beats_q;
   assign stall_cycles = stall_q;
`endif

endmodule
